// File: rtl/morse_key_classifier.sv
// Measures key mark/space durations in Morse units, classifies them into dots,
// dashes, letter gaps and word gaps, and queues the symbols in a 4-entry FIFO.
module morse_key_classifier #(
  parameter int  FREQUENCY = 12_000_000,
  parameter real UNIT_TIME = 0.06
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] event_in,
  output logic       key_on,
  output logic [1:0] sym_data,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       overflow
);

  localparam int UNIT_TICKS = $rtoi(UNIT_TIME * real'(FREQUENCY));
  localparam int CW         = $clog2(7 * UNIT_TICKS + 1);

  localparam logic [CW-1:0] C_DASH   = CW'(2 * UNIT_TICKS);
  localparam logic [CW-1:0] C_LETTER = CW'(3 * UNIT_TICKS);
  localparam logic [CW-1:0] C_MAX    = CW'(7 * UNIT_TICKS);

  localparam logic [1:0] EV_PRESS   = 2'd1;
  localparam logic [1:0] EV_RELEASE = 2'd2;

  localparam logic [1:0] SYM_DOT    = 2'd0;
  localparam logic [1:0] SYM_DASH   = 2'd1;
  localparam logic [1:0] SYM_LETTER = 2'd2;
  localparam logic [1:0] SYM_WORD   = 2'd3;

  // Handshake: the head entry (sym_data) transfers on a rising edge where
  // sym_valid & sym_ready; sym_data holds steady while sym_valid & !sym_ready.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            letter_sent_q, letter_sent_d;
  logic            key_on_q, key_on_d;
  logic            overflow_q, overflow_d;
  logic [1:0]      mem_q [4];
  logic [1:0]      mem_d [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;

  logic            push;
  logic [1:0]      push_sym;
  logic            push_ok;
  logic            pop;
  logic            full;
  logic [CW-1:0]   cnt_inc;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    letter_sent_d = letter_sent_q;
    key_on_d      = key_on_q;
    push          = 1'b0;
    push_sym      = SYM_DOT;
    cnt_inc       = (cnt_q == C_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (event_in == EV_PRESS) begin
          state_d  = ST_MARK;
          key_on_d = 1'b1;
        end
      end
      ST_MARK: begin
        if (event_in == EV_RELEASE) begin
          push          = 1'b1;
          push_sym      = (cnt_q < C_DASH) ? SYM_DOT : SYM_DASH;
          state_d       = ST_SPACE;
          cnt_d         = '0;
          key_on_d      = 1'b0;
          letter_sent_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SPACE: begin
        cnt_d = cnt_inc;
        if (cnt_q == C_LETTER && !letter_sent_q) begin
          push          = 1'b1;
          push_sym      = SYM_LETTER;
          letter_sent_d = 1'b1;
        end else if (cnt_q == C_MAX) begin
          push     = 1'b1;
          push_sym = SYM_WORD;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end
        // A press on a gap edge still enters MARK; the gap has already been queued.
        if (event_in == EV_PRESS) begin
          state_d  = ST_MARK;
          cnt_d    = '0;
          key_on_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pop        = (count_q != 3'd0) && sym_ready;
    full       = (count_q == 3'd4);
    push_ok    = push && (!full || pop);
    overflow_d = overflow_q | (push && !push_ok);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_sym;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      letter_sent_q <= 1'b0;
      key_on_q      <= 1'b0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < 4; i++) mem_q[i] <= SYM_DOT;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      letter_sent_q <= letter_sent_d;
      key_on_q      <= key_on_d;
      overflow_q    <= overflow_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign key_on    = key_on_q;
  assign sym_data  = mem_q[rd_ptr_q];
  assign sym_valid = (count_q != 3'd0);
  assign overflow  = overflow_q;

endmodule
